// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: per-boundary bundle widths, bubble control values
// and the pipe_stage_reg occupancy encoding.
package cpu_pipe_pkg;

    localparam int unsigned IFID_DATA_W  = 64;
    localparam int unsigned IFID_CTRL_W  = 8;
    localparam int unsigned IDEX_DATA_W  = 96;
    localparam int unsigned IDEX_CTRL_W  = 16;
    localparam int unsigned EXMEM_DATA_W = 96;
    localparam int unsigned EXMEM_CTRL_W = 16;
    localparam int unsigned MEMWB_DATA_W = 64;
    localparam int unsigned MEMWB_CTRL_W = 8;

    // All write enables deasserted: the bubble never commits architectural state.
    localparam logic [IFID_CTRL_W-1:0]  IFID_CTRL_BUBBLE  = '0;
    localparam logic [IDEX_CTRL_W-1:0]  IDEX_CTRL_BUBBLE  = '0;
    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_CTRL_BUBBLE = '0;
    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_CTRL_BUBBLE = '0;

    // Encoding doubles as the occupancy count.
    localparam logic [1:0] StEmpty = 2'd0;
    localparam logic [1:0] StOne   = 2'd1;
    localparam logic [1:0] StFull  = 2'd2;

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry ({valid, ctrl, data}) with asynchronous reset and load enable.
module pipe_entry_reg #(
    parameter int unsigned         WIDTH   = 113,
    parameter logic [WIDTH-1:0]    RST_VAL = '0
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_q <= RST_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble and an
// optional skid entry that makes in_ready a pure function of registered state.
module pipe_stage_reg
    import cpu_pipe_pkg::*;
#(
    parameter int unsigned        DATA_W      = 96,
    parameter int unsigned        CTRL_W      = 16,
    parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = '0,
    parameter bit                 SKID        = 1'b1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occ
);

    localparam int unsigned          ENTRY_W   = DATA_W + CTRL_W + 1;
    localparam logic [ENTRY_W-1:0]   ENTRY_RST = {1'b0, CTRL_BUBBLE, {DATA_W{1'b0}}};

    logic [1:0]         r_state;
    logic [1:0]         w_state_d;
    logic [ENTRY_W-1:0] w_head_q, w_head_d, w_skid_q, w_skid_d;
    logic [ENTRY_W-1:0] w_in_entry, w_head_bubble, w_skid_bubble;
    logic               w_head_ld, w_skid_ld;
    logic               w_in_xfer, w_out_xfer;

    assign out_valid = w_head_q[ENTRY_W-1];
    assign out_data  = w_head_q[DATA_W-1:0];
    assign out_ctrl  = out_valid ? w_head_q[DATA_W +: CTRL_W] : CTRL_BUBBLE;
    assign occ       = r_state;
    assign in_ready  = SKID ? (r_state != StFull) : (out_ready | ~out_valid);

    assign w_in_xfer  = in_valid & in_ready;
    assign w_out_xfer = out_valid & out_ready;

    assign w_in_entry = {1'b1, in_ctrl, in_data};
    // Invalidated entries keep their data so out_data never picks up X from the inputs.
    assign w_head_bubble = {1'b0, CTRL_BUBBLE, w_head_q[DATA_W-1:0]};
    assign w_skid_bubble = {1'b0, CTRL_BUBBLE, w_skid_q[DATA_W-1:0]};

    always_comb begin
        w_state_d = r_state;
        w_head_ld = 1'b0;
        w_head_d  = w_in_entry;
        w_skid_ld = 1'b0;
        w_skid_d  = w_in_entry;
        if (flush) begin
            w_state_d = StEmpty;
            w_head_ld = 1'b1;
            w_head_d  = w_head_bubble;
            w_skid_ld = 1'b1;
            w_skid_d  = w_skid_bubble;
        end else if (!SKID) begin
            if (w_in_xfer) begin
                w_state_d = StOne;
                w_head_ld = 1'b1;
            end else if (w_out_xfer) begin
                w_state_d = StEmpty;
                w_head_ld = 1'b1;
                w_head_d  = w_head_bubble;
            end
        end else begin
            case (r_state)
                StEmpty: begin
                    if (w_in_xfer) begin
                        w_state_d = StOne;
                        w_head_ld = 1'b1;
                    end
                end
                StOne: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_head_ld = 1'b1;
                    end else if (w_in_xfer) begin
                        w_state_d = StFull;
                        w_skid_ld = 1'b1;
                    end else if (w_out_xfer) begin
                        w_state_d = StEmpty;
                        w_head_ld = 1'b1;
                        w_head_d  = w_head_bubble;
                    end
                end
                StFull: begin
                    if (w_out_xfer) begin
                        w_state_d = StOne;
                        w_head_ld = 1'b1;
                        w_head_d  = w_skid_q;
                        w_skid_ld = 1'b1;
                        w_skid_d  = w_skid_bubble;
                    end
                end
                default: begin
                    w_state_d = StEmpty;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_d;
        end
    end

    pipe_entry_reg #(
        .WIDTH   (ENTRY_W),
        .RST_VAL (ENTRY_RST)
    ) u_head (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .i_load (w_head_ld),
        .i_d    (w_head_d),
        .o_q    (w_head_q)
    );

    pipe_entry_reg #(
        .WIDTH   (ENTRY_W),
        .RST_VAL (ENTRY_RST)
    ) u_skid (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .i_load (w_skid_ld),
        .i_d    (w_skid_d),
        .o_q    (w_skid_q)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: one SKID=1 and one SKID=0 instance, directed
// scenarios followed by random valid/ready traffic.
module tb_pipe_stage_reg;

    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic clk;
    logic rst_n;

    logic          a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready;
    logic [DW-1:0] a_in_data, a_out_data;
    logic [CW-1:0] a_in_ctrl, a_out_ctrl;
    logic [1:0]    a_occ;

    logic          b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready;
    logic [DW-1:0] b_in_data, b_out_data;
    logic [CW-1:0] b_in_ctrl, b_out_ctrl;
    logic [1:0]    b_occ;

    int checks = 0;
    int errors = 0;

    logic [DW+CW-1:0] qa[$];
    logic [DW+CW-1:0] qb[$];

    pipe_stage_reg #(
        .DATA_W      (DW),
        .CTRL_W      (CW),
        .CTRL_BUBBLE (16'h0000),
        .SKID        (1'b1)
    ) u_dut_a (
        .CLK       (clk),
        .RSTn      (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .in_ctrl   (a_in_ctrl),
        .flush     (a_flush),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_ctrl  (a_out_ctrl),
        .occ       (a_occ)
    );

    pipe_stage_reg #(
        .DATA_W      (DW),
        .CTRL_W      (CW),
        .CTRL_BUBBLE (16'h0000),
        .SKID        (1'b0)
    ) u_dut_b (
        .CLK       (clk),
        .RSTn      (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .in_ctrl   (b_in_ctrl),
        .flush     (b_flush),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_ctrl  (b_out_ctrl),
        .occ       (b_occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitors: expected entries are pushed on input transfers, popped on output transfers.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
        end else begin
            if (!a_out_valid) check("a_bubble_ctrl", 64'(a_out_ctrl), 64'h0);
            if (a_flush) begin
                qa.delete();
            end else begin
                if (a_out_valid && a_out_ready) begin
                    if (qa.size() == 0) check("a_spurious_out", 64'(qa.size()), 64'd1);
                    else check("a_order", 64'({a_out_ctrl, a_out_data}), 64'(qa.pop_front()));
                end
                if (a_in_valid && a_in_ready) qa.push_back({a_in_ctrl, a_in_data});
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            qb.delete();
        end else begin
            if (!b_out_valid) check("b_bubble_ctrl", 64'(b_out_ctrl), 64'h0);
            if (b_flush) begin
                qb.delete();
            end else begin
                if (b_out_valid && b_out_ready) begin
                    if (qb.size() == 0) check("b_spurious_out", 64'(qb.size()), 64'd1);
                    else check("b_order", 64'({b_out_ctrl, b_out_data}), 64'(qb.pop_front()));
                end
                if (b_in_valid && b_in_ready) qb.push_back({b_in_ctrl, b_in_data});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        {a_in_valid, a_flush, a_out_ready, b_in_valid, b_flush, b_out_ready} = '0;
        a_in_data = '0; a_in_ctrl = '0; b_in_data = '0; b_in_ctrl = '0;

        step();
        check("rst_out_valid", 64'(a_out_valid), 64'd0);
        check("rst_out_data", 64'(a_out_data), 64'd0);
        check("rst_out_ctrl", 64'(a_out_ctrl), 64'd0);
        check("rst_occ", 64'(a_occ), 64'd0);
        check("rst_in_ready", 64'(a_in_ready), 64'd1);
        check("rst_b_in_ready", 64'(b_in_ready), 64'd1);
        step();
        rst_n = 1'b1;

        // Streaming through SKID=1 with out_ready held high.
        a_out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = DW'(i);
            a_in_ctrl  = CW'(16'h0010 + i);
            step();
            check("stream_data", 64'(a_out_data), 64'(i));
            check("stream_occ", 64'(a_occ), 64'd1);
            check("stream_in_ready", 64'(a_in_ready), 64'd1);
        end
        a_in_valid = 1'b0;
        step();
        check("stream_drain_valid", 64'(a_out_valid), 64'd0);
        check("stream_drain_occ", 64'(a_occ), 64'd0);

        // Backpressure fills head then skid.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'hDEAD;
        a_in_ctrl   = 16'h0001;
        step();
        check("bp_occ1", 64'(a_occ), 64'd1);
        a_in_data = 32'hBEEF;
        a_in_ctrl = 16'h0002;
        step();
        check("bp_occ2", 64'(a_occ), 64'd2);
        check("bp_in_ready", 64'(a_in_ready), 64'd0);
        check("bp_head", 64'(a_out_data), 64'hDEAD);
        a_in_valid = 1'b0;
        step();
        check("bp_stall_head", 64'(a_out_data), 64'hDEAD);
        check("bp_stall_ctrl", 64'(a_out_ctrl), 64'h0001);
        a_out_ready = 1'b1;
        step();
        check("bp_second", 64'(a_out_data), 64'hBEEF);
        check("bp_occ_after_a", 64'(a_occ), 64'd1);
        check("bp_ready_back", 64'(a_in_ready), 64'd1);
        step();
        check("bp_empty", 64'(a_occ), 64'd0);

        // Flush from ONE: the simultaneous input is accepted and discarded.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h0D0D;
        a_in_ctrl   = 16'h00D0;
        step();
        a_flush   = 1'b1;
        a_in_data = 32'h0C0C;
        a_in_ctrl = 16'h00C0;
        step();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        check("flush1_occ", 64'(a_occ), 64'd0);
        check("flush1_valid", 64'(a_out_valid), 64'd0);
        check("flush1_in_ready", 64'(a_in_ready), 64'd1);
        a_out_ready = 1'b1;
        step();
        check("flush1_no_c", 64'(a_out_valid), 64'd0);

        // Flush from FULL with input presented.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h0E0E;
        a_in_ctrl   = 16'h00E0;
        step();
        a_in_data = 32'h0F0F;
        a_in_ctrl = 16'h00F0;
        step();
        check("flush2_pre_occ", 64'(a_occ), 64'd2);
        a_flush   = 1'b1;
        a_in_data = 32'h0C0C;
        a_in_ctrl = 16'h00C0;
        step();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        check("flush2_occ", 64'(a_occ), 64'd0);
        check("flush2_ctrl", 64'(a_out_ctrl), 64'h0);
        check("flush2_in_ready", 64'(a_in_ready), 64'd1);
        a_out_ready = 1'b1;
        step();
        check("flush2_no_c", 64'(a_out_valid), 64'd0);

        // Asynchronous reset while FULL.
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h1111;
        a_in_ctrl   = 16'h00A5;
        step();
        a_in_data = 32'h2222;
        a_in_ctrl = 16'h00A6;
        step();
        a_in_valid = 1'b0;
        check("arst_pre_occ", 64'(a_occ), 64'd2);
        check("arst_pre_ctrl", 64'(a_out_ctrl), 64'h00A5);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(a_out_valid), 64'd0);
        check("arst_ctrl", 64'(a_out_ctrl), 64'h0);
        check("arst_in_ready", 64'(a_in_ready), 64'd1);
        check("arst_occ", 64'(a_occ), 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // SKID=0: combinational out_ready -> in_ready.
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 32'h5555;
        b_in_ctrl   = 16'h0055;
        step();
        b_in_data = 32'h6666;
        b_in_ctrl = 16'h0066;
        #1;
        check("s0_valid", 64'(b_out_valid), 64'd1);
        check("s0_in_ready_low", 64'(b_in_ready), 64'd0);
        b_out_ready = 1'b1;
        #1;
        check("s0_in_ready_comb", 64'(b_in_ready), 64'd1);
        step();
        check("s0_loaded", 64'(b_out_data), 64'h6666);
        check("s0_occ", 64'(b_occ), 64'd1);
        b_in_valid = 1'b0;
        step();
        check("s0_empty", 64'(b_occ), 64'd0);

        // Random valid/ready on both builds.
        for (int n = 0; n < 10000; n++) begin
            a_in_valid  = 1'($urandom_range(1));
            a_out_ready = 1'($urandom_range(1));
            a_in_data   = $urandom();
            a_in_ctrl   = CW'($urandom());
            b_in_valid  = 1'($urandom_range(1));
            b_out_ready = 1'($urandom_range(1));
            b_in_data   = $urandom();
            b_in_ctrl   = CW'($urandom());
            step();
            if (b_occ > 2'd1) check("s0_occ_max", 64'(b_occ), 64'd1);
        end
        a_in_valid  = 1'b0;
        b_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        repeat (4) step();
        check("a_drained", 64'(qa.size()), 64'd0);
        check("b_drained", 64'(qb.size()), 64'd0);
        check("a_final_occ", 64'(a_occ), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the pipelined CPU. It replaces the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB), which have no reset and no stall. It carries a data bundle and a control bundle with a valid/ready handshake, synchronous flush-to-bubble and an optional skid entry that cuts the combinational ready path. One instance sits between each pair of adjacent stages.

Parameters:
DATA_W, 96, width of the data bundle (for example PC+4, ALU result, store data).
CTRL_W, 16, width of the control bundle (for example regWrite, memWrite, whatToReg, readMode, move, regWAddr).
CTRL_BUBBLE, 0, value the control bundle takes when the stage holds no valid instruction.
SKID, 1, 0 gives a single entry with combinational in_ready; 1 gives two entries with registered in_ready.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RSTn  input  1  asynchronous, active-low reset.
in_valid  input  1  upstream stage presents an instruction.
in_ready  output  1  this register accepts an instruction this cycle.
in_data  input  DATA_W  incoming data bundle.
in_ctrl  input  CTRL_W  incoming control bundle.
flush  input  1  synchronous kill of all held and incoming instructions.
out_valid  output  1  the register holds a valid instruction.
out_ready  input  1  downstream stage consumes the instruction this cycle.
out_data  output  DATA_W  data bundle of the head entry.
out_ctrl  output  CTRL_W  control bundle of the head entry; equals CTRL_BUBBLE whenever out_valid=0.
occ  output  2  number of entries held (0..2; never exceeds 1 when SKID=0).

Behaviour:
- Reset (RSTn=0, asynchronous): out_valid=0, out_data=0, out_ctrl=CTRL_BUBBLE, occ=0, in_ready=1, skid entry empty. Normal operation resumes on the first rising edge after RSTn goes high.
- Transfer definitions: an input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready. Both are evaluated at the rising edge.
- Latency is 1 cycle: data accepted at edge N is visible on out_* after edge N.
- SKID=0:
  - in_ready = out_ready | ~out_valid (combinational).
  - The head loads on every input transfer.
  - out_valid falls after an output transfer with no simultaneous input transfer.
- SKID=1, state machine EMPTY / ONE / FULL; in_ready is registered and equals (state != FULL).
  - EMPTY, input transfer -> ONE; the head loads the input.
  - ONE, input only -> FULL; the input goes to the skid entry and the head holds.
  - ONE, output only -> EMPTY.
  - ONE, input and output together -> ONE; the head loads the input.
  - FULL, output transfer -> ONE; the head loads from the skid entry. No input can be accepted because in_ready=0.
  - FULL, no output transfer -> all entries hold.
- Ordering: entries leave strictly in arrival order; nothing is duplicated or dropped except by flush.
- Stall: while out_ready=0 every held entry is stable, bit for bit, across cycles.
- Flush (takes priority over every other event in the same cycle):
  - Next state is EMPTY, out_valid=0, out_ctrl=CTRL_BUBBLE, occ=0, in_ready=1.
  - An input transfer in the flush cycle is accepted and discarded.
  - out_data value after flush is don't-care, but it must not be X after reset.
- Bubble rule: out_ctrl is forced to CTRL_BUBBLE whenever out_valid=0, so downstream write enables are never asserted by an empty stage.
- occ reflects the registered state only; there is no combinational path from inputs to occ.
- SKID=1 has no combinational paths from inputs to outputs. SKID=0 has exactly one, out_ready -> in_ready.

Decomposition:
- Shared package cpu_pipe_pkg holds the stage bundle widths per stage boundary (IFID_DATA_W, IDEX_CTRL_W, EXMEM_*, MEMWB_*) and the bubble control constants. It also holds the state encoding: EMPTY=2'd0, ONE=2'd1, FULL=2'd2.
- One sub-module, pipe_entry_reg: a DATA_W+CTRL_W+1 bit register with async active-low reset and load enable. It is instantiated twice, as head and skid entry.

Test Plan:
- Reset mid-stream: RSTn pulled low while occ=2 with out_ctrl=16'h00A5 -> out_valid=0, out_ctrl=16'h0000 and in_ready=1 immediately, before any clock edge.
- Streaming, SKID=1, out_ready held 1: in_data 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later each, occ stays 1 and in_ready stays 1.
- Backpressure: out_ready=0 and send A=32'hDEAD, B=32'hBEEF -> occ=2 and in_ready=0; out_data holds A. Raise out_ready -> A then B on consecutive cycles, and in_ready returns to 1 one cycle after A leaves.
- Flush with simultaneous input: occ=2, then flush=1 together with in_valid=1 (C) -> next cycle occ=0, out_valid=0, out_ctrl=CTRL_BUBBLE; C never appears on the output.
- SKID=0 build: out_valid=1 and out_ready=0 -> in_ready=0 in the same cycle. Drive out_ready=1 -> in_ready=1 combinationally, and the input is loaded at the edge.
- Random valid/ready, 10k cycles, both SKID values: a scoreboard checks in-order, lossless delivery and the invariant (out_valid=0 implies out_ctrl=CTRL_BUBBLE).
